fila_param: RTL

Parametrised successor of the 8x8 fila queue: a synchronous FIFO of DEPTH words of DATA_WIDTH bits in the clk_10KHz domain. Push and pop are edge-triggered from slow, level-held control inputs (buttons or FSM strobes); one rising edge produces exactly one operation. Adds full/empty flags, a parametrised length output and simultaneous push/pop. It replaces fila wherever a buffer between slow producers and consumers is needed.

---
 rtl/fila_param.sv | 86 ++++++++
 1 files changed

// File: rtl/fila_param.sv
// Synchronous FIFO of DEPTH x DATA_WIDTH with edge-triggered push/pop from level-held controls.
// Optional macro FILA_OVERWRITE_EN: a push into a full queue overwrites the oldest word instead of being dropped.
module fila_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_10KHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enqueue_in,
  input  logic                  dequeue_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LEN_W-1:0]      len_out,
  output logic                  full_out,
  output logic                  empty_out
);

  localparam int PTR_W = $clog2(DEPTH);

  // Control protocol: enqueue_in/dequeue_in are levels; only the cycle in which a
  // level is seen high after being low (per the registered copy) requests an operation.
  // There is no back-pressure: a request that cannot be honoured is simply not performed.

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  enq_q;
  logic                  deq_q;
  logic                  push_req;
  logic                  pop_req;
  logic                  do_push;
  logic                  do_pop;
  logic                  drop_head;
  logic                  len_inc;
  logic                  len_dec;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    // Explicit wrap so DEPTH need not be a power of two.
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_out  = (len_out == LEN_W'(DEPTH));
  assign empty_out = (len_out == '0);

  always_comb begin
    push_req = enqueue_in & ~enq_q;
    pop_req  = dequeue_in & ~deq_q;
    do_pop   = pop_req & ~empty_out;
`ifdef FILA_OVERWRITE_EN
    do_push   = push_req;
    drop_head = push_req & full_out & ~do_pop;
`else
    do_push   = push_req & (~full_out | do_pop);
    drop_head = 1'b0;
`endif
    // A push into a full queue never grows it; it either pairs with a pop or overwrites.
    len_inc = do_push & ~do_pop & ~full_out;
    len_dec = do_pop & ~do_push;
  end

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      len_out  <= '0;
      data_out <= '0;
      enq_q    <= 1'b0;
      deq_q    <= 1'b0;
    end else begin
      enq_q <= enqueue_in;
      deq_q <= dequeue_in;
      if (do_push) tail <= next_ptr(tail);
      if (do_pop || drop_head) head <= next_ptr(head);
      if (do_pop) data_out <= mem[head];
      if (len_inc) len_out <= len_out + LEN_W'(1);
      else if (len_dec) len_out <= len_out - LEN_W'(1);
    end
  end

  // Storage is not reset; only the pointers and length define valid contents.
  always_ff @(posedge clk_10KHz) begin
    if (!reset && do_push) mem[tail] <= data_in;
  end

endmodule
